fast_frame_sequencer: RTL

//  Frame-level controller in front of the FAST+NMS corner pipeline. Accepts a valid/ready pixel

---
 rtl/fast_seq_pkg.sv | 26 ++
 rtl/fast_seq_corner_fifo.sv | 51 +++++
 rtl/fast_frame_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fast_seq_pkg.sv
// Shared types for the FAST frame sequencer: FSM state encoding, the corner record
// and default frame geometry.
package fast_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    FLUSH  = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } corner_t;

  localparam int unsigned DEF_COL_NUM = 640;
  localparam int unsigned DEF_ROW_NUM = 480;
  localparam int unsigned FRAME_PIX   = DEF_COL_NUM * DEF_ROW_NUM;

  function automatic int unsigned frame_pix(input int unsigned cols, input int unsigned rows);
    return cols * rows;
  endfunction

endpackage

// File: rtl/fast_seq_corner_fifo.sv
// Synchronous corner FIFO. The read word comes straight from storage flops and is
// forced to zero while empty, so downstream outputs stay clean after reset.
module fast_seq_corner_fifo
  import fast_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  corner_t       wdata_i,
  input  logic          pop_i,
  output corner_t       rdata_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  corner_t       mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fast_frame_sequencer.sv
// Frame controller ahead of the FAST+NMS pipeline: streams pixels, flushes, buffers corners.
// Define FAST_SEQ_CORNER_LIMIT_EN to cap captured corners per frame at MAX_CORNERS.
module fast_frame_sequencer
  import fast_seq_pkg::*;
#(
  parameter int unsigned COL_NUM      = DEF_COL_NUM,
  parameter int unsigned ROW_NUM      = DEF_ROW_NUM,
  parameter int unsigned PIXEL_WIDTH  = 8,
  parameter int unsigned FLUSH_CYCLES = 3 * DEF_COL_NUM + 16,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned AF_MARGIN    = 2,
  parameter int unsigned MAX_CORNERS  = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [PIXEL_WIDTH-1:0] s_pix_i,
  input  logic                   s_vld_i,
  output logic                   s_rdy_o,
  output logic                   core_ce_o,
  output logic [PIXEL_WIDTH-1:0] core_data_o,
  input  logic                   core_iscorner_i,
  input  logic [9:0]             core_x_i,
  input  logic [9:0]             core_y_i,
  output logic [9:0]             m_x_o,
  output logic [9:0]             m_y_o,
  output logic                   m_vld_o,
  input  logic                   m_rdy_i,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic [15:0]            corner_count_o,
  output logic                   overflow_o
);

  localparam int unsigned FPIX = frame_pix(COL_NUM, ROW_NUM);
  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PW   = $clog2(FPIX + 1);
  localparam int unsigned FW   = $clog2(FLUSH_CYCLES + 1);
`ifdef FAST_SEQ_CORNER_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  seq_state_e    state_q;
  logic [PW-1:0] pix_cnt_q;
  logic [FW-1:0] flush_cnt_q;
  logic [15:0]   corner_cnt_q, corner_count_q;
  logic          frame_done_q, overflow_q;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty, afull, accept, corner_hit, cap_hit, push, cnt_inc;
  corner_t       fifo_dout;

  // Holding ce low at the almost-full mark leaves room for the corner already in flight.
  assign afull       = fifo_count >= CW'(FIFO_DEPTH - AF_MARGIN);
  assign s_rdy_o     = (state_q == STREAM) && !afull;
  assign accept      = s_vld_i && s_rdy_o;
  assign core_ce_o   = accept || ((state_q == FLUSH) && !afull);
  assign core_data_o = (state_q == STREAM) ? s_pix_i : '0;

  assign corner_hit = core_iscorner_i && core_ce_o;
  assign cap_hit    = LIMIT_EN && (corner_cnt_q == 16'(MAX_CORNERS));
  assign push       = corner_hit && !cap_hit;
  assign cnt_inc    = push && (corner_cnt_q != 16'hFFFF);

  fast_seq_corner_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i ('{x: core_x_i, y: core_y_i}),
    .pop_i   (m_rdy_i),
    .rdata_o (fifo_dout),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      pix_cnt_q      <= '0;
      flush_cnt_q    <= '0;
      corner_cnt_q   <= '0;
      corner_count_q <= '0;
      frame_done_q   <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (accept) pix_cnt_q <= pix_cnt_q + 1'b1;
      if ((state_q == FLUSH) && core_ce_o) flush_cnt_q <= flush_cnt_q + 1'b1;
      if (cnt_inc) corner_cnt_q <= corner_cnt_q + 1'b1;
      if (corner_hit && cap_hit) overflow_q <= 1'b1;
      unique case (state_q)
        IDLE: if (start_i) begin
          state_q    <= STREAM;
          overflow_q <= 1'b0;
        end
        STREAM: if (accept && (pix_cnt_q == PW'(FPIX - 1))) state_q <= FLUSH;
        FLUSH:  if (core_ce_o && (flush_cnt_q == FW'(FLUSH_CYCLES - 1))) state_q <= DRAIN;
        DRAIN: if (fifo_empty) begin
          state_q        <= DONE;
          frame_done_q   <= 1'b1;
          corner_count_q <= corner_cnt_q;
        end
        DONE: begin
          state_q      <= IDLE;
          pix_cnt_q    <= '0;
          flush_cnt_q  <= '0;
          corner_cnt_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_x_o          = fifo_dout.x;
  assign m_y_o          = fifo_dout.y;
  assign m_vld_o        = !fifo_empty;
  assign busy_o         = (state_q != IDLE);
  assign frame_done_o   = frame_done_q;
  assign corner_count_o = corner_count_q;
  assign overflow_o     = overflow_q;

endmodule
